muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, directly downstream of the decoder.
- Consumes decoded ops with exUnitType == ExUnitType_MulDiv, plus the op's mulDivType and the two integer source operands.
- Produces a 32-bit result for integer register writeback.
- Single request in flight; the pipeline stalls on busy.

---
 rtl/muldiv_unit_pkg.sv | 26 ++
 rtl/muldiv_unit_div_iter_core.sv | 50 +++++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Command encoding follows the RV32M funct3 ordering.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mul_div_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mul_div_state_e;

  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN           = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit_div_iter_core.sv
// Restoring divide datapath on unsigned magnitudes, one quotient bit per step.
// quotient/remainder are the post-step values so the owner can capture them on the final step.
module muldiv_unit_div_iter_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] rem_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] dsr_q;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  // The dividend shifts out of quo_q while quotient bits shift in behind it.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dsr_q};
    if (diff[W]) begin
      remainder = shifted[W-1:0];
      quotient  = {quo_q[W-2:0], 1'b0};
    end else begin
      remainder = diff[W-1:0];
      quotient  = {quo_q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, single request in flight.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mulDivType,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(XLEN);

  mul_div_state_e state, state_next;
  mul_div_type_e  op, op_in;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             is_mul_in, is_rem_in, sgn1_in, sgn2_in;
  logic             div_zero, div_ovf, special, accept, finish;
  logic [XLEN-1:0]  mag1, mag2, special_res;
  logic [XLEN-1:0]  quo_mag, rem_mag, div_raw, div_res, mul_res, final_res;
  logic [2*XLEN-1:0] full_prod;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] fa, fb;
`else
  logic [2*XLEN-1:0] mcand, prod, step_prod;
  logic [XLEN-1:0]   mlr;
`endif

  // Request decode, only meaningful in the Idle cycle.
  always_comb begin
    op_in     = mul_div_type_e'(mulDivType);
    is_mul_in = !mulDivType[2];
    is_rem_in = mulDivType[2] & mulDivType[1];
    sgn1_in   = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && src1[XLEN-1];
    sgn2_in   = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && src2[XLEN-1];
    mag1      = sgn1_in ? -src1 : src1;
    mag2      = sgn2_in ? -src2 : src2;
    div_zero  = (src2 == '0);
    div_ovf   = (op_in inside {OP_DIV, OP_REM}) && (src1 == INT_MIN) && (src2 == '1);
    special   = !is_mul_in && (div_zero || div_ovf);
    if (div_zero) special_res = is_rem_in ? src1 : DIV_ZERO_QUOTIENT;
    else          special_res = is_rem_in ? '0 : INT_MIN;
  end

  assign accept = (state == ST_IDLE) && start && !flush;

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = is_mul_in ? ST_MUL : (special ? ST_DONE : ST_DIV);
`ifdef MULDIV_FAST_MUL_EN
      ST_MUL:  state_next = ST_DONE;
`else
      ST_MUL:  if (cnt == CNT_W'(1)) state_next = ST_DONE;
`endif
      ST_DIV:  if (cnt == CNT_W'(1)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  assign finish = (state inside {ST_MUL, ST_DIV}) && (state_next == ST_DONE);

  muldiv_unit_div_iter_core #(.W(XLEN)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && !is_mul_in),
    .step      (state == ST_DIV),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (quo_mag),
    .remainder (rem_mag)
  );

  // Sign fixup happens once, on the transition into Done.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    full_prod = (2*XLEN)'(fa) * (2*XLEN)'(fb);
`else
    step_prod = prod + (mlr[0] ? mcand : '0);
    full_prod = neg ? -step_prod : step_prod;
`endif
    div_raw   = (op inside {OP_REM, OP_REMU}) ? rem_mag : quo_mag;
    div_res   = neg ? -div_raw : div_raw;
    mul_res   = (op == OP_MUL) ? full_prod[XLEN-1:0] : full_prod[2*XLEN-1:XLEN];
    final_res = (state == ST_MUL) ? mul_res : div_res;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= OP_MUL;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
`ifdef MULDIV_FAST_MUL_EN
      fa     <= '0;
      fb     <= '0;
`else
      mcand  <= '0;
      prod   <= '0;
      mlr    <= '0;
`endif
    end else if (accept) begin
      op  <= op_in;
      cnt <= ITERS;
      neg <= is_rem_in ? sgn1_in : (sgn1_in ^ sgn2_in);
`ifdef MULDIV_FAST_MUL_EN
      fa  <= {sgn1_in, src1};
      fb  <= {sgn2_in, src2};
`else
      mcand <= {{XLEN{1'b0}}, mag1};
      mlr   <= mag2;
      prod  <= '0;
`endif
      if (special) result <= special_res;
    end else if (state inside {ST_MUL, ST_DIV}) begin
      cnt <= cnt - CNT_W'(1);
`ifndef MULDIV_FAST_MUL_EN
      if (state == ST_MUL) begin
        prod  <= step_prod;
        mcand <= mcand << 1;
        mlr   <= mlr >> 1;
      end
`endif
      if (finish) result <= final_res;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, flush/reset/busy scenarios, random ops.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int WAIT_BUDGET = 80;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  mul_div_type;
  logic [31:0] src1, src2;
  logic        busy, done;
  logic [31:0] result;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mulDivType (mul_div_type),
    .src1       (src1),
    .src2       (src2),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  // Reference model built from plain SV arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b)));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  // Drives start for one cycle (cycle N) and returns at mid-cycle N+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    start = 1'b1; mul_div_type = op; src1 = a; src2 = b;
    exp_q.push_back(exp);
    lat_q.push_back(exp_latency(op, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc is the offset from the start cycle.
  task automatic wait_done(input int cyc0, output int cyc, output logic got);
    cyc = cyc0;
    while (!done && cyc < WAIT_BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    got = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; mul_div_type = '0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    compared++; if (result !== 32'h0) begin mismatched++; $display("FAIL reset_result: got %h want 0", result); end
  endtask

  task automatic test_divide();
    logic [2:0]  ops[6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_1234, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[6]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex[6]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'h0};
    int   lt[6] = '{DIV_LAT, DIV_LAT, 1, 1, 1, 1};
    int   cyc, l;
    logic got;
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], ex[i]);
      wait_done(1, cyc, got);
      e = exp_q.pop_front(); l = lat_q.pop_front();
      compared++;
      if (!got || result !== e) begin
        mismatched++; $display("FAIL div_result[%0d]: got %h (done=%b) want %h", i, result, got, e);
      end
      compared++;
      if (cyc != lt[i] || cyc != l) begin
        mismatched++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, cyc, lt[i]);
      end
      last_exp = e;
      @(negedge clk);
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        mismatched++; $display("FAIL div_pulse[%0d]: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_multiply();
    logic [2:0]  ops[4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] as[4]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs[4]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex[4]  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int   cyc, l;
    logic got;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], ex[i]);
      wait_done(1, cyc, got);
      e = exp_q.pop_front(); l = lat_q.pop_front();
      compared++;
      if (!got || result !== e) begin
        mismatched++; $display("FAIL mul_result[%0d]: got %h (done=%b) want %h", i, result, got, e);
      end
      compared++;
      if (cyc != MUL_LAT || cyc != l) begin
        mismatched++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, cyc, MUL_LAT);
      end
      last_exp = e;
      @(negedge clk);
      compared++;
      if (done !== 1'b0) begin mismatched++; $display("FAIL mul_pulse[%0d]: done=%b want 0", i, done); end
    end
  endtask

  task automatic test_flush();
    logic saw = 1'b0;
    int   cyc;
    logic got;
    logic [31:0] e;
    issue(3'd5, 32'h0000_1000, 32'd3, model(3'd5, 32'h0000_1000, 32'd3));
    for (int i = 1; i < 10; i++) begin
      saw |= done;
      @(negedge clk);
    end
    flush = 1'b1;
    saw |= done;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_front()); void'(lat_q.pop_front());
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL flush_busy: got %b want 0", busy); end
    compared++; if (done !== 1'b0 || saw !== 1'b0) begin mismatched++; $display("FAIL flush_done: done=%b seen=%b want 0 0", done, saw); end
    compared++; if (result !== last_exp) begin mismatched++; $display("FAIL flush_result: got %h want %h", result, last_exp); end
    // New request in the cycle right after the flush.
    start = 1'b1; mul_div_type = 3'd5; src1 = 32'd1000; src2 = 32'd7;
    exp_q.push_back(32'd142); lat_q.push_back(DIV_LAT);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, cyc, got);
    e = exp_q.pop_front(); void'(lat_q.pop_front());
    compared++; if (!got || result !== e) begin mismatched++; $display("FAIL flush_restart_result: got %h want %h", result, e); end
    compared++; if (cyc != DIV_LAT) begin mismatched++; $display("FAIL flush_restart_latency: got %0d want %0d", cyc, DIV_LAT); end
    last_exp = e;
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int   cyc;
    logic got;
    logic [31:0] e;
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    start = 1'b1; mul_div_type = 3'd7; src1 = 32'd5; src2 = 32'd0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(4, cyc, got);
    e = exp_q.pop_front(); void'(lat_q.pop_front());
    compared++; if (!got || result !== e) begin mismatched++; $display("FAIL busy_ignore_result: got %h want %h", result, e); end
    compared++; if (cyc != DIV_LAT) begin mismatched++; $display("FAIL busy_ignore_latency: got %0d want %0d", cyc, DIV_LAT); end
    last_exp = e;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    issue(3'd0, 32'd9, 32'd9, 32'd81);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front()); void'(lat_q.pop_front());
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rst_mid_done: got %b want 0", done); end
    compared++; if (result !== 32'h0) begin mismatched++; $display("FAIL rst_mid_result: got %h want 0", result); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, e;
    int   cyc, l;
    logic got;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom() >> $urandom_range(0, 28));
      issue(op, a, b, model(op, a, b));
      wait_done(1, cyc, got);
      e = exp_q.pop_front(); l = lat_q.pop_front();
      compared++;
      if (!got || result !== e) begin
        mismatched++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, result, e);
      end
      compared++;
      if (cyc != l) begin mismatched++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, cyc, l); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_multiply();
    test_flush();
    test_busy_ignore();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
